// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regbank_arbiter
// Description : Two-master round-robin write arbiter in front of a small
//               register bank. One write commits every two cycles, and a
//               combinational port reads any register.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_arbiter #(
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             prio
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sel;
    logic             r_prio;
    logic [AW-1:0]    r_waddr;
    logic [WIDTH-1:0] r_wdata;
    logic [WIDTH-1:0] r_regs [NREGS];

    logic             w_grant_vld;
    logic             w_grant_sel;

    // Arbitration and next-state decode; requests are only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        w_grant_vld  = 1'b0;
        w_grant_sel  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1) begin
                    w_grant_vld = 1'b1;
                    w_grant_sel = r_prio;
                end else if (req0) begin
                    w_grant_vld = 1'b1;
                    w_grant_sel = 1'b0;
                end else if (req1) begin
                    w_grant_vld = 1'b1;
                    w_grant_sel = 1'b1;
                end
                if (w_grant_vld) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the winner's address/data at the grant edge and rotate priority
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_prio  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_grant_vld) begin
            r_sel   <= w_grant_sel;
            r_prio  <= ~w_grant_sel;
            r_waddr <= w_grant_sel ? addr1 : addr0;
            r_wdata <= w_grant_sel ? data1 : data0;
        end
    end

    // Register bank: commit on the edge closing the WRITE cycle; reset wins
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_WRITE) begin
            r_regs[r_waddr] <= r_wdata;
        end
    end

    // Handshake outputs decode only registered state, never the live requests
    assign ack0  = (r_state == S_WRITE) && !r_sel;
    assign ack1  = (r_state == S_WRITE) &&  r_sel;
    assign busy  = (r_state == S_WRITE);
    assign prio  = r_prio;
    assign rdata = r_regs[raddr];

endmodule
`default_nettype wire

// File: doc/regbank_arbiter.md
# regbank_arbiter

Two-requester write arbiter and storage for a small bank of WIDTH-bit registers in the CPU datapath. Two write masters, e.g. ALU writeback and load unit, request writes with a level req/ack handshake. A round-robin scheduler grants one request at a time, and a two-state FSM commits the write. A combinational read port exposes any register.

## Interface

Parameters:
- WIDTH, default 4: data width of each register.
- AW, default 2: address width; bank holds 2**AW registers.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  write request, master 0; level, held until ack0.
- addr0  input  AW  target register, master 0.
- data0  input  WIDTH  write data, master 0.
- ack0  output  1  one-cycle pulse: master 0 write is committing this cycle.
- req1  input  1  write request, master 1.
- addr1  input  AW  target register, master 1.
- data1  input  WIDTH  write data, master 1.
- ack1  output  1  one-cycle pulse for master 1.
- raddr  input  AW  read address.
- rdata  output  WIDTH  combinational read: contents of register raddr.
- busy  output  1  high while FSM is in WRITE.
- prio  output  1  round-robin pointer: master favoured on the next contention.

## Operation

- State: regs[0..2**AW-1], FSM {IDLE, WRITE}, prio, latched sel/waddr/wdata.
- IDLE:
  - No req: stay IDLE.
  - Exactly one req: grant that master.
  - Both req: grant master == prio.
  - On grant, capture that master's addr/data into waddr/wdata, set sel, go to WRITE.
  - prio <= ~granted master, also for uncontended grants.
- WRITE:
  - ack[sel] = 1 and busy = 1.
  - At the closing edge, regs[waddr] <= wdata and state <= IDLE.
  - reqs are ignored during WRITE; no arbitration happens.
- Capture rule: addr/data are sampled only at the grant edge. Changes afterwards do not affect the committed write.
- Requester duty: drop req in the cycle after ack. A req still high in the IDLE cycle after ack is a new request and is arbitrated normally; the other master waiting wins under round-robin.
- rdata = regs[raddr], purely combinational. During WRITE it shows the old value; the new value appears after the commit edge.
- Both masters targeting the same address: each write commits in grant order. Final value is the later grant's data.

## Timing

- Reset values:
  - All regs = 0.
  - State = IDLE; ack0 = ack1 = 0; busy = 0.
  - prio = 0, so master 0 is favoured first.
  - waddr/wdata/sel = 0.
- ack0, ack1 and busy are registered: decoded from state, with no combinational path from req.
- Latency:
  - req sampled high in IDLE at cycle N.
  - ack high during cycle N+1.
  - Data readable on rdata from cycle N+2.
- Throughput: one write per 2 cycles. The bank is never written on consecutive edges.
- Contention: both req held from cycle N with prio = 0.
  - ack0 in N+1, ack1 in N+3.
  - prio = 1 after N, and 0 after N+2.
- Reset mid-operation: reset high in WRITE aborts the write. The reg is not updated, all regs are cleared, and ack drops the next cycle. Reset overrides every other update.
- ack0 and ack1 are never high in the same cycle.

## Test plan

- Reset: assert reset 2 cycles with req0 = 1 -> ack0 = ack1 = 0, busy = 0, prio = 0, rdata = 0 for raddr 0..3.
- Single write: req0 = 1, addr0 = 2, data0 = 4'b1010 at N, drop after ack -> ack0 in N+1 only; rdata(raddr = 2) = 1010 from N+2; other regs remain 0.
- Contention fairness:
  - req0 (addr 1, 0011) and req1 (addr 1, 1111) held from N -> ack0 at N+1, ack1 at N+3; final reg1 = 1111.
  - Repeat with prio = 1 -> master 1 served first, final reg1 = 0011.
- Capture isolation: after grant, change data0 from 0101 to 1111 during WRITE -> committed value 0101; busy = 1 for exactly one cycle.
- Reset mid-write: reg3 = 1100, then req1 writes addr 3 = 0110; assert reset in the WRITE cycle -> reg3 = 0, ack1 low next cycle, state IDLE, prio = 0.
- Sustained streaming: both reqs held high for 12 cycles -> acks alternate 0,1,0,1… with one idle cycle between acks; never simultaneous; 6 total writes.
